// File: rtl/pp_buffer_pkg.sv
// ============================================================================
// Module  : pp_buffer_pkg
// Brief   : Shared types and helpers for the ping-pong frame buffer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package pp_buffer_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_t;

  // A zero or oversized frame length selects a full-depth frame.
  function automatic int unsigned clamp_len(input int unsigned frame_len,
                                            input int unsigned depth);
    if (frame_len == 0 || frame_len > depth) return depth;
    return frame_len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pp_bank_ram.sv
// ============================================================================
// Module  : pp_bank_ram
// Brief   : Simple dual-port RAM holding both banks, registered read port.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module pp_bank_ram #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 384,
  parameter int AW     = $clog2(2 * DEPTH)
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2*DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the output register is reset; the array itself keeps its contents.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/pp_buffer_gen.sv
// ============================================================================
// Module  : pp_buffer_gen
// Brief   : Parametrised ping-pong frame buffer with release handshake.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module pp_buffer_gen
  import pp_buffer_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 384,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [ADDR_W:0]   frame_len,
  input  logic              valid_in,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic [DATA_W-1:0] wrdata,
  output logic              ready_out,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rdaddress,
  output logic [DATA_W-1:0] q,
  output logic              valid_out,
  output logic              bank_swap,
  output logic              overflow
);

  typedef logic [ADDR_W:0] len_t;
  localparam len_t c_depth = len_t'(DEPTH);

  bank_state_t state_q [2];
  bank_state_t state_d [2];
  len_t        len_q   [2];
  len_t        len_d   [2];
  len_t        wr_cnt_q, wr_cnt_d;
  len_t        rd_cnt_q, rd_cnt_d;
  logic        wr_sel_q, wr_sel_d;
  logic        overflow_q, overflow_d;
  logic        init_q, valid_q, swap_q;

  logic w_rd_sel, w_wr_acc, w_addr_ok, w_wr_store, w_wr_done;
  logic w_rd_acc, w_rd_done, w_swap;
  len_t w_len_new, w_wr_len, w_wr_addr, w_rd_addr;

  assign w_rd_sel  = ~wr_sel_q;
  assign ready_out = init_q && (state_q[wr_sel_q] == EMPTY);
  assign w_len_new = len_t'(clamp_len(32'(frame_len), DEPTH));
  // The first write of a frame sees the incoming length, later writes the latched one.
  assign w_wr_len  = (wr_cnt_q == '0) ? w_len_new : len_q[wr_sel_q];

  assign w_wr_acc   = valid_in && ready_out;
  assign w_addr_ok  = {1'b0, wraddress} < w_wr_len;
  assign w_wr_store = w_wr_acc && w_addr_ok;
  assign w_wr_done  = w_wr_acc && ((wr_cnt_q + len_t'(1)) == w_wr_len);

  assign w_rd_acc  = rd_en && (state_q[w_rd_sel] == FULL);
  assign w_rd_done = w_rd_acc && ((rd_cnt_q + len_t'(1)) == len_q[w_rd_sel]);

  assign w_swap = ((state_q[wr_sel_q] == FULL) || w_wr_done) &&
                  ((state_q[w_rd_sel] == EMPTY) || w_rd_done);

  assign w_wr_addr = {1'b0, wraddress} + (wr_sel_q ? c_depth : '0);
  assign w_rd_addr = {1'b0, rdaddress} + (w_rd_sel ? c_depth : '0);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    wr_sel_d   = wr_sel_q;
    overflow_d = overflow_q;

    if (w_wr_acc) begin
      if (wr_cnt_q == '0) len_d[wr_sel_q] = w_len_new;
      wr_cnt_d = w_wr_done ? '0 : wr_cnt_q + len_t'(1);
      if (w_wr_done) state_d[wr_sel_q] = FULL;
    end

    if ((valid_in && !ready_out) || (w_wr_acc && !w_addr_ok)) overflow_d = 1'b1;

    if (w_rd_acc) begin
      rd_cnt_d = w_rd_done ? '0 : rd_cnt_q + len_t'(1);
      if (w_rd_done) state_d[w_rd_sel] = EMPTY;
    end

    if (w_swap) begin
      wr_sel_d          = ~wr_sel_q;
      state_d[wr_sel_q] = FULL;
      state_d[w_rd_sel] = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      wr_sel_q   <= 1'b0;
      overflow_q <= 1'b0;
      init_q     <= 1'b0;
      valid_q    <= 1'b0;
      swap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_sel_q   <= wr_sel_d;
      overflow_q <= overflow_d;
      init_q     <= 1'b1;
      valid_q    <= w_rd_acc;
      swap_q     <= w_swap;
    end
  end

  assign valid_out = valid_q;
  assign bank_swap = swap_q;
  assign overflow  = overflow_q;

  pp_bank_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (ADDR_W + 1)
  ) u_ram (
    .clk     (clk),
    .resetN  (resetN),
    .we_i    (w_wr_store),
    .waddr_i (w_wr_addr),
    .wdata_i (wrdata),
    .re_i    (w_rd_acc),
    .raddr_i (w_rd_addr),
    .rdata_o (q)
  );

endmodule

`default_nettype wire

// File: tb/tb_pp_buffer_gen.sv
// ============================================================================
// Module  : tb_pp_buffer_gen
// Brief   : Directed self-checking bench for pp_buffer_gen.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pp_buffer_gen;

  localparam int DW = 2;
  localparam int DP = 384;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic [AW:0]   frame_len = '0;
  logic          valid_in = 1'b0;
  logic [AW-1:0] wraddress = '0;
  logic [DW-1:0] wrdata = '0;
  logic          ready_out;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rdaddress = '0;
  logic [DW-1:0] q;
  logic          valid_out;
  logic          bank_swap;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [191:0] vec;

  always #5 clk = ~clk;

  pp_buffer_gen #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .frame_len (frame_len),
    .valid_in  (valid_in),
    .wraddress (wraddress),
    .wrdata    (wrdata),
    .ready_out (ready_out),
    .rd_en     (rd_en),
    .rdaddress (rdaddress),
    .q         (q),
    .valid_out (valid_out),
    .bank_swap (bank_swap),
    .overflow  (overflow)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Seed 100: constant 2'b10; seed 101: the reference bit vector, MSB first.
  function automatic logic [1:0] pat(input int seed, input int i);
    int t;
    if (seed == 100) return 2'b10;
    if (seed == 101) return {1'b0, vec[191-i]};
    t = i ^ (i >> 2) ^ (seed * 5);
    return t[1:0];
  endfunction

  task automatic wr_frame(input int n, input int seed, input int fl, input bit exp_swap);
    frame_len = 10'(fl);
    for (int i = 0; i < n; i++) begin
      valid_in  = 1'b1;
      wraddress = 9'(i);
      wrdata    = pat(seed, i);
      chk_eq("wr_ready", ready_out, 1);
      tick();
      chk_eq("wr_swap", bank_swap, exp_swap && (i == n - 1));
    end
    valid_in = 1'b0;
  endtask

  task automatic rd_frame(input int n, input int seed, input bit slow);
    for (int i = 0; i < n; i++) begin
      rd_en     = 1'b1;
      rdaddress = 9'(i);
      tick();
      chk_eq("rd_valid", valid_out, 1);
      chk_eq("rd_data", q, pat(seed, i));
      if (slow) begin
        chk_eq("slow_ready", ready_out, i == n - 1);
        chk_eq("slow_swap", bank_swap, i == n - 1);
      end else begin
        chk_eq("rd_ready", ready_out, 1);
        chk_eq("rd_swap", bank_swap, 0);
      end
    end
    rd_en = 1'b0;
  endtask

  initial begin : main
    int f;
    int a;
    vec = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

    // Reset state and release
    repeat (3) tick();
    chk_eq("rst_ready", ready_out, 0);
    chk_eq("rst_valid", valid_out, 0);
    chk_eq("rst_swap", bank_swap, 0);
    chk_eq("rst_ovf", overflow, 0);
    chk_eq("rst_q", q, 0);
    resetN = 1'b1;
    chk_eq("rel_ready_pre", ready_out, 0);
    tick();
    chk_eq("rel_ready", ready_out, 1);

    // Fill and drain the reference vector
    wr_frame(192, 101, 192, 1'b1);
    rd_frame(192, 101, 1'b0);
    rd_en = 1'b1;
    tick();
    chk_eq("rd_empty_valid", valid_out, 0);
    rd_en = 1'b0;

    // Ten back-to-back frames at full rate
    frame_len = 10'd192;
    for (int c = 0; c < 11 * 192; c++) begin
      f = c / 192;
      a = c % 192;
      valid_in  = (c < 1920);
      wraddress = 9'(a);
      wrdata    = pat(10 + f, a);
      rd_en     = (c >= 192);
      rdaddress = 9'(a);
      if (c < 1920) chk_eq("st_ready", ready_out, 1);
      tick();
      if (c >= 192) begin
        chk_eq("st_valid", valid_out, 1);
        chk_eq("st_data", q, pat(10 + f - 1, a));
      end
      chk_eq("st_swap", bank_swap, (a == 191) && (c < 1920));
    end
    valid_in = 1'b0;
    rd_en    = 1'b0;
    chk_eq("st_ovf", overflow, 0);

    // Slow reader: second frame waits, dropped writes set overflow
    wr_frame(192, 20, 192, 1'b1);
    wr_frame(192, 21, 192, 1'b0);
    chk_eq("slow_ready_full", ready_out, 0);
    for (int i = 0; i < 3; i++) begin
      valid_in  = 1'b1;
      wraddress = 9'(i);
      wrdata    = ~pat(21, i);
      tick();
      chk_eq("drop_ovf", overflow, 1);
      chk_eq("drop_ready", ready_out, 0);
    end
    valid_in = 1'b0;
    rd_frame(192, 20, 1'b1);
    rd_frame(192, 21, 1'b0);

    // Short frame, then frame_len=0 meaning full depth
    wr_frame(48, 100, 48, 1'b1);
    rd_frame(48, 100, 1'b0);
    wr_frame(384, 30, 0, 1'b1);
    rd_frame(384, 30, 1'b0);

    // Mid-frame asynchronous reset
    frame_len = 10'd192;
    for (int i = 0; i < 100; i++) begin
      valid_in  = 1'b1;
      wraddress = 9'(i);
      wrdata    = pat(40, i);
      tick();
    end
    valid_in = 1'b0;
    #2 resetN = 1'b0;
    #1;
    chk_eq("mid_ready", ready_out, 0);
    chk_eq("mid_valid", valid_out, 0);
    chk_eq("mid_swap", bank_swap, 0);
    chk_eq("mid_ovf", overflow, 0);
    chk_eq("mid_q", q, 0);
    tick();
    resetN = 1'b1;
    chk_eq("mid_rel_pre", ready_out, 0);
    tick();
    chk_eq("mid_rel_ready", ready_out, 1);
    wr_frame(192, 7, 192, 1'b1);
    rd_frame(192, 7, 1'b0);

    // Out-of-range address: prefill both banks, then a 48-word frame
    wr_frame(64, 5, 64, 1'b1);
    rd_frame(64, 5, 1'b0);
    wr_frame(64, 6, 64, 1'b1);
    rd_frame(64, 6, 1'b0);
    frame_len = 10'd48;
    for (int i = 0; i < 48; i++) begin
      valid_in  = 1'b1;
      wraddress = (i == 5) ? 9'd60 : 9'(i);
      wrdata    = (i == 5) ? ~pat(5, 60) : pat(8, i);
      if (i == 5) chk_eq("oor_ovf_pre", overflow, 0);
      tick();
      if (i == 5) chk_eq("oor_ovf", overflow, 1);
      chk_eq("oor_swap", bank_swap, i == 47);
    end
    valid_in = 1'b0;
    for (int i = 0; i < 48; i++) begin
      rd_en     = 1'b1;
      rdaddress = (i == 5) ? 9'd60 : 9'(i);
      tick();
      chk_eq("oor_valid", valid_out, 1);
      chk_eq("oor_data", q, (i == 5) ? pat(5, 60) : pat(8, i));
    end
    rd_en = 1'b0;
    tick();
    chk_eq("oor_done_valid", valid_out, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pp_buffer_gen.md
# pp_buffer_gen

Parametrised ping-pong frame buffer for the WiMAX PHY transmit chain, placed between bit-serial producers (randomizer/FEC) and address-permuting consumers (interleaver). It generalises the 1-bit/192-entry buffer to configurable data width and depth, with a per-frame programmable length, an explicit read-side release handshake, and overflow detection. One bank fills while the other drains, and the banks swap when both sides are done.

## Interface
- DATA_W, 1: width of each stored word.
- DEPTH, 384: maximum frame length per bank, in words.
- ADDR_W, $clog2(DEPTH): address width.
- clk  in  1  clock; all logic is rising-edge.
- resetN  in  1  asynchronous active-low reset.
- frame_len  in  ADDR_W+1  frame length in words; 0 or >DEPTH is treated as DEPTH.
- valid_in  in  1  write request.
- wraddress  in  ADDR_W  write address within the frame.
- wrdata  in  DATA_W  write data.
- ready_out  out  1  write bank can accept a write.
- rd_en  in  1  read request.
- rdaddress  in  ADDR_W  read address within the frame.
- q  out  DATA_W  read data.
- valid_out  out  1  q is valid.
- bank_swap  out  1  one-cycle pulse when the banks swap.
- overflow  out  1  sticky flag: a write was dropped.

## Operation
- Two banks, A (0) and B (1). wr_sel selects the write bank and the read bank is ~wr_sel. Each bank has a state, EMPTY or FULL, and a stored length.
- A write is accepted when valid_in && ready_out. The length is latched from frame_len on the first accepted write of a frame (wr_cnt==0).
- Each accepted write stores wrdata at {wr_sel,wraddress} and increments wr_cnt. If wraddress ≥ stored length, the write is counted but not stored, and overflow is set.
- When the write that makes wr_cnt reach the length is accepted, wr_cnt clears and the write bank becomes FULL.
- A read is accepted when rd_en and the read bank is FULL. rd_en while the read bank is EMPTY is ignored and valid_out stays 0.
- Each accepted read increments rd_cnt. On the read that makes rd_cnt reach the read bank's length, the read bank becomes EMPTY and rd_cnt clears.
- Swap rule: the banks swap on the edge where the write bank is FULL (or becomes FULL) and the read bank is EMPTY (or becomes EMPTY on the same edge). On a swap, wr_sel toggles, the new read bank is FULL and the new write bank is EMPTY.
- ready_out = (write bank EMPTY) && ~in_reset. If the write bank is full and not swappable, ready_out stays low until the read release edge.
- valid_in while ready_out==0 drops the write and sets overflow. overflow is cleared only by reset.
- Reset (asynchronous, at any point including mid-frame) clears both banks to EMPTY, and sets wr_sel=0, counters=0, q=0, valid_out=0, bank_swap=0, overflow=0, ready_out=0. RAM contents are not cleared.

## Timing
- ready_out rises on the first rising edge after resetN deasserts.
- Read latency is 1 cycle: q and valid_out are registered from the accepted rd_en.
- Back-to-back frames stream at full rate with no bubble when the reader finishes no later than the writer.
- bank_swap is high for the single cycle following the swap edge.
- The first read of a new frame may be issued in the cycle after the swap edge.
- In a full-rate stream, the write/read that completes a frame, and the read that starts the next frame on the new bank, may both occur in consecutive cycles.

## Structure
- Package pp_buffer_pkg holds the bank_state_t enum {EMPTY, FULL} and the function clamp_len(frame_len) returning a DEPTH-clamped length.
- Sub-module pp_bank_ram: simple dual-port RAM with 2*DEPTH×DATA_W entries, a synchronous write port, and a registered read port. It is inferable by synthesis.
- The top level holds the counters, the bank state and the swap logic, in roughly 150–250 lines.

## Test plan
- **Reset and fill:** DATA_W=1, DEPTH=192, frame_len=192. Release reset, wait for ready_out, write bits of 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA. Expect bank_swap at the 192nd write edge, ready_out held high, and 192 reads returning the identical vector with valid_out one cycle later.
- **Continuous streaming:** 10 back-to-back frames, writing and reading simultaneously each cycle. Expect every frame to match, ready_out never low, and overflow=0.
- **Slow reader:** after the 2nd frame fills, hold rd_en=0. Expect ready_out=0 until the 192nd read, and the swap on that edge. valid_in pulses issued meanwhile set overflow=1 and do not corrupt data.
- **Short frame with wrap:** frame_len=48 and DATA_W=2 with pattern 2'b10. Expect the swap after 48 writes, and reads of addresses 0..47 returning 2'b10. frame_len=0 yields 384-word frames.
- **Mid-operation reset:** assert resetN=0 after 100 writes. Expect every output to be 0 immediately. After release, a full frame still round-trips correctly.
- **Out-of-range address:** frame_len=48 with wraddress=60. Expect the write counted, no RAM write, and overflow=1.
